// File: rtl/decodificador_teclado_pkg.sv
// Shared types and helpers for the keypad decoder.
//   senhaPac_t       : 20-digit buffer, digits[0] is the newest key
//   TECLA_*          : special digit codes (star, hash, empty slot)
//   teclado_state_t  : scanner FSM states
//   row_lin          : active-low row drive pattern for a row index
//   one_col_low      : true when exactly one column line is low
//   col_index        : column index of the single low column
//   decode_tecla     : (row, col) -> digit code
package decodificador_teclado_pkg;

  localparam logic [3:0] TECLA_AST   = 4'hA;
  localparam logic [3:0] TECLA_HASH  = 4'hB;
  localparam logic [3:0] TECLA_VAZIA = 4'hF;
  localparam int         N_DIGITOS   = 20;

  typedef struct packed {
    logic [N_DIGITOS-1:0][3:0] digits;
  } senhaPac_t;

  localparam senhaPac_t SENHA_VAZIA = senhaPac_t'({N_DIGITOS{TECLA_VAZIA}});

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    EMIT     = 2'd2,
    RELEASE  = 2'd3
  } teclado_state_t;

  function automatic logic [3:0] row_lin(input logic [1:0] row);
    logic [3:0] res;
    res = ~(4'b0001 << row);
    return res;
  endfunction

  function automatic logic one_col_low(input logic [2:0] cols);
    return (cols == 3'b110) || (cols == 3'b101) || (cols == 3'b011);
  endfunction

  function automatic logic [1:0] col_index(input logic [2:0] cols);
    logic [1:0] res;
    case (cols)
      3'b110:  res = 2'd0;
      3'b101:  res = 2'd1;
      default: res = 2'd2;
    endcase
    return res;
  endfunction

  function automatic logic [3:0] decode_tecla(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] res;
    if (row == 2'd3) begin
      case (col)
        2'd0:    res = TECLA_AST;
        2'd1:    res = 4'h0;
        default: res = TECLA_HASH;
      endcase
    end else begin
      // Rows 0..2 hold 1..9 in reading order.
      res = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/decodificador_teclado_sincronizador_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
//   clk : destination clock
//   rst : synchronous active-high reset, loads RESET_VALUE into both flops
//   d   : asynchronous input
//   q   : synchronized output (two cycles of latency)
module sincronizador_2ff #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/decodificador_teclado.sv
// 3x4 matrix keypad scanner with debounce and a 20-digit shift buffer.
//   clk, rst      : clock, synchronous active-high reset
//   teclado_en    : enable; low holds the block idle with an empty buffer
//   col_matriz    : keypad columns, active-low, asynchronous
//   lin_matriz    : keypad rows, active-low, registered, at most one low
//   digitos_value : digit buffer, digits[0] newest
//   digitos_valid : one-cycle pulse when a new key lands in digitos_value
//   estado        : current FSM state (debug)
//
// Handshake: digitos_valid is a single-cycle strobe with no ready; the
// consumer must take digitos_value in the cycle the strobe is high.
module decodificador_teclado
  import decodificador_teclado_pkg::*;
#(
  parameter int SCAN_CYCLES     = 1000,
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES  = 5000000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           teclado_en,
  input  logic [2:0]     col_matriz,
  output logic [3:0]     lin_matriz,
  output senhaPac_t      digitos_value,
  output logic           digitos_valid,
  output teclado_state_t estado
);

  localparam int CNT_MAX = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDLE_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0]  SCAN_N = CNT_W'(SCAN_CYCLES);
  localparam logic [CNT_W-1:0]  DEB_N  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_N = IDLE_W'(TIMEOUT_CYCLES);

  teclado_state_t    state;
  logic [1:0]        row;
  logic [CNT_W-1:0]  cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic [2:0]        col_cap;
  logic [2:0]        cols;
  logic [3:0]        code;

  sincronizador_2ff #(
    .WIDTH      (3),
    .RESET_VALUE(3'b111)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (col_matriz),
    .q  (cols)
  );

  assign code   = decode_tecla(row, col_index(col_cap));
  assign estado = state;

  // The scan counter counts cycles the current row has been on the pins.
  // Whenever the row changes, lin_matriz changes on that same edge, so the
  // counter restarts at 1 there; after reset/disable it starts at 0 because
  // the first enabled edge is the one that first drives row 0.
  always_ff @(posedge clk) begin
    if (rst || !teclado_en) begin
      state         <= SCAN;
      row           <= 2'd0;
      cnt           <= '0;
      idle_cnt      <= '0;
      col_cap       <= 3'b111;
      lin_matriz    <= 4'b1111;
      digitos_value <= SENHA_VAZIA;
      digitos_valid <= 1'b0;
    end else begin
      digitos_valid <= 1'b0;
      lin_matriz    <= row_lin(row);

      // Partial-entry timeout; an EMIT below overrides the counter reset.
      if (idle_cnt == IDLE_N) begin
        digitos_value <= SENHA_VAZIA;
        idle_cnt      <= '0;
      end else if (state == SCAN && digitos_value != SENHA_VAZIA) begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end

      case (state)
        SCAN: begin
          if (cnt == SCAN_N) begin
            if (one_col_low(cols)) begin
              col_cap <= cols;
              cnt     <= '0;
              state   <= DEBOUNCE;
            end else begin
              row        <= row + 2'd1;
              lin_matriz <= row_lin(row + 2'd1);
              cnt        <= CNT_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DEBOUNCE: begin
          if (cnt == DEB_N) begin
            digitos_value.digits <= {digitos_value.digits[N_DIGITOS-2:0], code};
            digitos_valid        <= 1'b1;
            idle_cnt             <= '0;
            state                <= EMIT;
          end else if (cols == col_cap) begin
            cnt <= cnt + CNT_W'(1);
          end else begin
            row        <= row + 2'd1;
            lin_matriz <= row_lin(row + 2'd1);
            cnt        <= CNT_W'(1);
            state      <= SCAN;
          end
        end

        EMIT: begin
          // The strobe cycle shows the terminator; the buffer empties after.
          if (digitos_value.digits[0] == TECLA_AST || digitos_value.digits[0] == TECLA_HASH) begin
            digitos_value <= SENHA_VAZIA;
          end
          cnt   <= '0;
          state <= RELEASE;
        end

        RELEASE: begin
          if (cnt == DEB_N) begin
            row        <= row + 2'd1;
            lin_matriz <= row_lin(row + 2'd1);
            cnt        <= CNT_W'(1);
            state      <= SCAN;
          end else if (cols == 3'b111) begin
            cnt <= cnt + CNT_W'(1);
          end else begin
            cnt <= '0;
          end
        end

        default: begin
          state <= SCAN;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decodificador_teclado.sv
// Directed bench for decodificador_teclado: a keypad model pulls a column
// low while its row is driven; expected values are hand-derived constants
// plus a shift-register model of the digit buffer.
module tb_decodificador_teclado;
  import decodificador_teclado_pkg::*;

  localparam int SC = 4;
  localparam int DC = 8;
  localparam int TC = 200;
  localparam logic [79:0] ALL_F = {80{1'b1}};

  // ---------------- clock / reset ----------------
  logic           clk = 1'b0;
  logic           rst;
  logic           teclado_en;
  logic [2:0]     col_matriz;
  logic [3:0]     lin_matriz;
  senhaPac_t      digitos_value;
  logic           digitos_valid;
  teclado_state_t estado;

  always #5 clk = ~clk;

  decodificador_teclado #(
    .SCAN_CYCLES    (SC),
    .DEBOUNCE_CYCLES(DC),
    .TIMEOUT_CYCLES (TC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .teclado_en   (teclado_en),
    .col_matriz   (col_matriz),
    .lin_matriz   (lin_matriz),
    .digitos_value(digitos_value),
    .digitos_valid(digitos_valid),
    .estado       (estado)
  );

  // ---------------- keypad model ----------------
  logic       key_down;
  logic [1:0] key_row;
  logic [1:0] key_col;

  always_comb begin
    col_matriz = 3'b111;
    if (key_down && !lin_matriz[key_row]) col_matriz[key_col] = 1'b0;
  end

  // ---------------- scoreboard ----------------
  int          n_checks  = 0;
  int          n_err     = 0;
  int          pulse_cnt = 0;
  logic [79:0] last_value;
  logic [79:0] exp_digits;

  always @(negedge clk) begin
    if (digitos_valid) begin
      pulse_cnt  = pulse_cnt + 1;
      last_value = digitos_value;
    end
  end

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_key(input logic [3:0] k);
    case (k)
      4'h1: begin key_row = 2'd0; key_col = 2'd0; end
      4'h2: begin key_row = 2'd0; key_col = 2'd1; end
      4'h3: begin key_row = 2'd0; key_col = 2'd2; end
      4'h4: begin key_row = 2'd1; key_col = 2'd0; end
      4'h5: begin key_row = 2'd1; key_col = 2'd1; end
      4'h6: begin key_row = 2'd1; key_col = 2'd2; end
      4'h7: begin key_row = 2'd2; key_col = 2'd0; end
      4'h8: begin key_row = 2'd2; key_col = 2'd1; end
      4'h9: begin key_row = 2'd2; key_col = 2'd2; end
      4'hA: begin key_row = 2'd3; key_col = 2'd0; end
      4'h0: begin key_row = 2'd3; key_col = 2'd1; end
      default: begin key_row = 2'd3; key_col = 2'd2; end
    endcase
  endtask

  task automatic wait_state(input teclado_state_t s, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (estado == s) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Presses a key cleanly; returns at the negedge where the strobe is seen.
  // lat counts cycles from first observing DEBOUNCE to the strobe.
  task automatic press_key(input logic [3:0] k, output bit got, output int lat);
    bit ok;
    set_key(k);
    key_down = 1'b1;
    got = 1'b0;
    lat = 0;
    wait_state(DEBOUNCE, 100, ok);
    if (ok) begin
      for (int i = 1; i <= 40; i++) begin
        @(negedge clk);
        if (digitos_valid) begin
          got = 1'b1;
          lat = i;
          break;
        end
      end
    end
  endtask

  // Releases the key; 'after' is the buffer one cycle after the strobe.
  task automatic release_key(output logic [79:0] after);
    key_down = 1'b0;
    @(negedge clk);
    after = digitos_value;
    check("valid_single_cycle", 80'(digitos_valid), 80'(0));
    repeat (13) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  logic [3:0]  exp_lin [4];
  logic [3:0]  seq5 [6];
  logic [79:0] after;
  bit          got;
  bit          ok;
  int          lat;
  int          p0;
  int          n_clr;
  logic [3:0]  k;

  initial begin
    exp_lin = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seq5    = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hB};
    rst = 1'b1;
    teclado_en = 1'b1;
    key_down = 1'b0;
    key_row = 2'd0;
    key_col = 2'd0;
    exp_digits = ALL_F;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_lin", 80'(lin_matriz), 80'(4'b1111));
    check("rst_digits", digitos_value, ALL_F);
    check("rst_valid", 80'(digitos_valid), 80'(0));
    check("rst_state", 80'(estado), 80'(SCAN));

    // Row walk, SC cycles per row, then wrap to row 0
    rst = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < SC; c++) begin
        @(negedge clk);
        check($sformatf("walk_r%0d_c%0d", r, c), 80'(lin_matriz), 80'(exp_lin[r]));
      end
    end
    @(negedge clk);
    check("walk_wrap", 80'(lin_matriz), 80'(4'b1110));

    // Keys 1..5 then '#'
    for (int i = 0; i < 6; i++) begin
      k = seq5[i];
      press_key(k, got, lat);
      check($sformatf("seq_pulse_%0d", i), 80'(got), 80'(1));
      check($sformatf("seq_latency_%0d", i), 80'(lat), 80'(DC + 1));
      exp_digits = {exp_digits[75:0], k};
      check($sformatf("seq_digits_%0d", i), digitos_value, exp_digits);
      release_key(after);
      if (i == 4) check("seq_after5", after, {60'hFFFF_FFFF_FFFF_FFF, 20'h12345});
    end
    check("hash_clears", after, ALL_F);
    exp_digits = ALL_F;

    // Key 7 bouncing, then held and released: one strobe
    p0 = pulse_cnt;
    set_key(4'h7);
    key_down = 1'b1;
    for (int i = 0; i < 10; i++) begin
      repeat (3) @(negedge clk);
      key_down = ~key_down;
    end
    key_down = 1'b1;
    repeat (40) @(negedge clk);
    key_down = 1'b0;
    repeat (14) @(negedge clk);
    check("bounce_pulses", 80'(pulse_cnt - p0), 80'(1));
    exp_digits = {exp_digits[75:0], 4'h7};
    check("bounce_value", last_value, exp_digits);

    // Key 0 held long: no auto-repeat; pressed again: second strobe
    p0 = pulse_cnt;
    set_key(4'h0);
    key_down = 1'b1;
    repeat (100) @(negedge clk);
    key_down = 1'b0;
    repeat (12) @(negedge clk);
    check("hold_pulses", 80'(pulse_cnt - p0), 80'(1));
    exp_digits = {exp_digits[75:0], 4'h0};
    press_key(4'h0, got, lat);
    check("repress_pulse", 80'(got), 80'(1));
    exp_digits = {exp_digits[75:0], 4'h0};
    check("repress_digits", digitos_value, exp_digits);
    release_key(after);

    // Key 9 then idle: timeout clears with no strobe
    press_key(4'h9, got, lat);
    check("t9_pulse", 80'(got), 80'(1));
    exp_digits = {exp_digits[75:0], 4'h9};
    check("t9_digits", digitos_value, exp_digits);
    release_key(after);
    p0 = pulse_cnt;
    repeat (136) @(negedge clk);
    check("timeout_not_early", digitos_value, exp_digits);
    ok = 1'b0;
    n_clr = 0;
    for (int i = 1; i <= 150; i++) begin
      @(negedge clk);
      if (digitos_value == ALL_F) begin
        ok = 1'b1;
        n_clr = i;
        break;
      end
    end
    check("timeout_clears", 80'(ok), 80'(1));
    check("timeout_window", 80'(n_clr >= 58 && n_clr <= 66), 80'(1));
    check("timeout_no_pulse", 80'(pulse_cnt - p0), 80'(0));
    exp_digits = ALL_F;

    // 21 digits: oldest shifts out, digits[19] holds the 2nd key
    for (int i = 0; i < 21; i++) begin
      k = 4'((i % 9) + 1);
      press_key(k, got, lat);
      check($sformatf("ovf_pulse_%0d", i), 80'(got), 80'(1));
      exp_digits = {exp_digits[75:0], k};
      release_key(after);
    end
    check("ovf_digits", digitos_value, exp_digits);
    check("ovf_digit19", 80'(digitos_value.digits[19]), 80'(4'h2));

    // Enable low for one cycle during DEBOUNCE of key 5
    p0 = pulse_cnt;
    set_key(4'h5);
    key_down = 1'b1;
    wait_state(DEBOUNCE, 100, ok);
    check("en_reach_debounce", 80'(ok), 80'(1));
    repeat (3) @(negedge clk);
    teclado_en = 1'b0;
    @(negedge clk);
    check("en_lin", 80'(lin_matriz), 80'(4'b1111));
    check("en_digits", digitos_value, ALL_F);
    check("en_valid", 80'(digitos_valid), 80'(0));
    check("en_state", 80'(estado), 80'(SCAN));
    teclado_en = 1'b1;
    key_down = 1'b0;
    @(negedge clk);
    check("en_restart_row0", 80'(lin_matriz), 80'(4'b1110));
    repeat (30) @(negedge clk);
    check("en_no_pulse", 80'(pulse_cnt - p0), 80'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
